// File: rtl/rect_raster.sv
// Axis-aligned rectangle rasteriser: walks the rectangle in raster order and
// offers each on-screen pixel downstream over a valid/ready handshake.
module rect_raster #(
    parameter int COORD_W  = 11,
    parameter int COLOR_W  = 8,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic signed [COORD_W-1:0] x0,
    input  logic signed [COORD_W-1:0] y0,
    input  logic signed [COORD_W-1:0] x1,
    input  logic signed [COORD_W-1:0] y1,
    input  logic                      mode,
    input  logic [COLOR_W-1:0]        color_in,
    input  logic                      ready,
    output logic signed [COORD_W-1:0] x,
    output logic signed [COORD_W-1:0] y,
    output logic [COLOR_W-1:0]        color,
    output logic                      valid,
    output logic                      busy,
    output logic                      done,
    output logic [1:0]                dbg_state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DRAW = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic signed [COORD_W-1:0] ONE = COORD_W'(1);

    logic [1:0]                state;
    logic signed [COORD_W-1:0] x_r, y_r;
    logic signed [COORD_W-1:0] xmin, xmax, ymin, ymax;
    logic                      mode_r;
    logic [COLOR_W-1:0]        color_r;

    logic signed [31:0]        x_ext, y_ext;
    logic                      on_screen;
    logic                      advance;
    logic                      row_end, last, skip;
    logic signed [COORD_W-1:0] x_nxt, y_nxt;

    // Handshake: a pixel is transferred on a rising edge where valid and ready
    // are both high; while valid is high and ready low, x, y and color hold.
    // Off-screen positions drop valid and are stepped over in one cycle.
    always_comb begin
        x_ext     = 32'(x_r);
        y_ext     = 32'(y_r);
        on_screen = (x_ext >= 0) && (x_ext < SCREEN_W) &&
                    (y_ext >= 0) && (y_ext < SCREEN_H);
        valid     = (state == DRAW) && on_screen;
        advance   = (state == DRAW) && (!valid || ready);
    end

    // Outline rows strictly between the top and bottom edges only visit the
    // two side columns, so xmin jumps straight to xmax.
    always_comb begin
        row_end = (x_r == xmax);
        last    = row_end && (y_r == ymax);
        skip    = mode_r && (x_r == xmin) && (y_r != ymin) && (y_r != ymax);
        x_nxt   = x_r + ONE;
        y_nxt   = y_r;
        if (row_end) begin
            x_nxt = xmin;
            y_nxt = y_r + ONE;
        end else if (skip) begin
            x_nxt = xmax;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            x_r     <= '0;
            y_r     <= '0;
            xmin    <= '0;
            xmax    <= '0;
            ymin    <= '0;
            ymax    <= '0;
            mode_r  <= 1'b0;
            color_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        xmin    <= (x0 < x1) ? x0 : x1;
                        xmax    <= (x0 < x1) ? x1 : x0;
                        ymin    <= (y0 < y1) ? y0 : y1;
                        ymax    <= (y0 < y1) ? y1 : y0;
                        x_r     <= (x0 < x1) ? x0 : x1;
                        y_r     <= (y0 < y1) ? y0 : y1;
                        mode_r  <= mode;
                        color_r <= color_in;
                        state   <= DRAW;
                    end
                end
                DRAW: begin
                    if (advance) begin
                        if (last) begin
                            state <= DONE;
                        end else begin
                            x_r <= x_nxt;
                            y_r <= y_nxt;
                        end
                    end
                end
                DONE: begin
                    if (!start) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign x         = x_r;
    assign y         = y_r;
    assign color     = color_r;
    assign busy      = (state == DRAW);
    assign done      = (state == DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_rect_raster.sv
// Directed bench for rect_raster: expected pixels are queued as each draw is
// issued and a negedge monitor pops one per accepted handshake.
module tb_rect_raster;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic signed [10:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic               mode = 1'b0;
    logic [7:0]         color_in = '0;
    logic               ready = 1'b1;
    logic signed [10:0] x, y;
    logic [7:0]         color;
    logic               valid, busy, done;
    logic [1:0]         dbg_state;

    int checks = 0;
    int passes = 0;

    // {color, x, y}
    logic [29:0] exp_q[$];

    rect_raster dut (
        .clk(clk), .reset(reset), .start(start),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .mode(mode), .color_in(color_in), .ready(ready),
        .x(x), .y(y), .color(color), .valid(valid),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    function automatic logic [29:0] pk(int px, int py, logic [7:0] c);
        return {c, 11'(px), 11'(py)};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!reset && valid && ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL pixel: unexpected x=%0d y=%0d color=%0h", x, y, color);
            end else begin
                logic [29:0] e;
                e = exp_q.pop_front();
                if ({color, x, y} === e) passes++;
                else $display("FAIL pixel: got c=%0h x=%0d y=%0d, expected c=%0h x=%0d y=%0d",
                              color, x, y, e[29:22], $signed(e[21:11]), $signed(e[10:0]));
            end
        end
    end

    // driver: issue one draw, count DRAW cycles until done
    task automatic run_rect(string name, int ax, int ay, int bx, int by, logic m,
                            logic [7:0] c, int exp_cycles, bit rand_ready);
        int n;
        x0 = 11'(ax); y0 = 11'(ay); x1 = 11'(bx); y1 = 11'(by);
        mode = m; color_in = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        x0 = 11'($urandom_range(0, 2047)); y0 = 11'($urandom_range(0, 2047));
        mode = ~m; color_in = ~c;
        n = 0;
        while (!done && n < 500) begin
            if (rand_ready) ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        ready = 1'b1;
        chk({name, " reached done"}, 32'(done), 32'd1);
        if (exp_cycles >= 0) chk({name, " draw cycles"}, n, exp_cycles);
        chk({name, " all pixels seen"}, exp_q.size(), 0);
        @(posedge clk); #1;
        chk({name, " back to idle"}, 32'(dbg_state), 32'd0);
    endtask

    initial begin
        int n;
        // reset
        repeat (2) @(posedge clk);
        #1;
        chk("reset x", 32'(x), 0);
        chk("reset y", 32'(y), 0);
        chk("reset color", 32'(color), 0);
        chk("reset valid", 32'(valid), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset state", 32'(dbg_state), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // filled 3x2, corners reversed
        exp_q.push_back(pk(1, 1, 8'h3c)); exp_q.push_back(pk(2, 1, 8'h3c));
        exp_q.push_back(pk(3, 1, 8'h3c)); exp_q.push_back(pk(1, 2, 8'h3c));
        exp_q.push_back(pk(2, 2, 8'h3c)); exp_q.push_back(pk(3, 2, 8'h3c));
        run_rect("fill3x2", 3, 2, 1, 1, 1'b0, 8'h3c, 6, 0);

        // outline 4x4
        exp_q.push_back(pk(0, 0, 8'ha1)); exp_q.push_back(pk(1, 0, 8'ha1));
        exp_q.push_back(pk(2, 0, 8'ha1)); exp_q.push_back(pk(3, 0, 8'ha1));
        exp_q.push_back(pk(0, 1, 8'ha1)); exp_q.push_back(pk(3, 1, 8'ha1));
        exp_q.push_back(pk(0, 2, 8'ha1)); exp_q.push_back(pk(3, 2, 8'ha1));
        exp_q.push_back(pk(0, 3, 8'ha1)); exp_q.push_back(pk(1, 3, 8'ha1));
        exp_q.push_back(pk(2, 3, 8'ha1)); exp_q.push_back(pk(3, 3, 8'ha1));
        run_rect("outline4x4", 0, 0, 3, 3, 1'b1, 8'ha1, 12, 0);

        // partly off-screen row
        exp_q.push_back(pk(0, 0, 8'h07)); exp_q.push_back(pk(1, 0, 8'h07));
        run_rect("offscreen", -2, 0, 1, 0, 1'b0, 8'h07, 4, 0);

        // degenerate outline (single row) must be traversed fully
        exp_q.push_back(pk(4, 7, 8'h11)); exp_q.push_back(pk(5, 7, 8'h11));
        exp_q.push_back(pk(6, 7, 8'h11));
        run_rect("outline1row", 6, 7, 4, 7, 1'b1, 8'h11, 3, 0);

        // filled 3x2 with random backpressure
        exp_q.push_back(pk(2, 1, 8'hc3)); exp_q.push_back(pk(3, 1, 8'hc3));
        exp_q.push_back(pk(4, 1, 8'hc3)); exp_q.push_back(pk(2, 2, 8'hc3));
        exp_q.push_back(pk(3, 2, 8'hc3)); exp_q.push_back(pk(4, 2, 8'hc3));
        run_rect("backpressure", 4, 2, 2, 1, 1'b0, 8'hc3, -1, 1);

        // 1x1 with ready low for 3 cycles
        exp_q.push_back(pk(5, 5, 8'h99));
        ready = 1'b0;
        x0 = 11'd5; y0 = 11'd5; x1 = 11'd5; y1 = 11'd5; mode = 1'b0; color_in = 8'h99;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall valid", 32'(valid), 1);
            chk("stall xy", 32'({x, y}), 32'({11'sd5, 11'sd5}));
            @(posedge clk); #1;
        end
        chk("stall valid 4th", 32'(valid), 1);
        ready = 1'b1;
        @(posedge clk); #1;
        chk("1x1 done", 32'(done), 1);
        chk("1x1 accepted once", exp_q.size(), 0);
        @(posedge clk); #1;

        // reset mid-draw of 10x10, start held through reset
        for (int i = 0; i < 3; i++) exp_q.push_back(pk(i, 0, 8'h5a));
        x0 = 11'd0; y0 = 11'd0; x1 = 11'd9; y1 = 11'd9; mode = 1'b0; color_in = 8'h5a;
        start = 1'b1;
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midreset state", 32'(dbg_state), 0);
        chk("midreset xy", 32'({x, y}), 0);
        chk("midreset color", 32'(color), 0);
        chk("midreset valid", 32'(valid), 0);
        chk("midreset busy/done", 32'({busy, done}), 0);
        chk("midreset partial", exp_q.size(), 0);
        for (int j = 0; j < 10; j++)
            for (int i = 0; i < 10; i++) exp_q.push_back(pk(i, j, 8'h5a));
        reset = 1'b0;
        @(posedge clk); #1;
        chk("redraw first xy", 32'({x, y}), 0);
        chk("redraw busy", 32'(busy), 1);
        n = 1;
        while (!done && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("redraw cycles", n, 101);
        chk("redraw all pixels", exp_q.size(), 0);
        chk("done holds xy", 32'({x, y}), 32'({11'sd9, 11'sd9}));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("done held by start", 32'(done), 1);
        end
        start = 1'b0;
        @(posedge clk); #1;
        chk("idle after release", 32'({busy, done}), 0);
        @(posedge clk); #1;
        chk("no new draw", 32'(dbg_state), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/rect_raster.md
RECT_RASTER -- requirements
Module: rect_raster

Interface
REQ-001 Parameter COORD_W, default 11, signed coordinate width of all coordinate ports.
REQ-002 Parameter COLOR_W, default 8, width of the colour pass-through.
REQ-003 Parameter SCREEN_W, default 640, visible width in pixels; legal x is 0..SCREEN_W-1.
REQ-004 Parameter SCREEN_H, default 480, visible height in pixels; legal y is 0..SCREEN_H-1.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  level request; sampled only in IDLE.
REQ-008 x0, y0, x1, y1  input  COORD_W each, signed  opposite corners, any order.
REQ-009 mode  input  1  0 = filled rectangle, 1 = outline only.
REQ-010 color_in  input  COLOR_W  colour captured with the corners.
REQ-011 ready  input  1  downstream accepts the current pixel.
REQ-012 x, y  output  COORD_W each, signed  current pixel coordinate.
REQ-013 color  output  COLOR_W  captured colour.
REQ-014 valid  output  1  current pixel is on-screen and offered downstream.
REQ-015 busy  output  1  high in DRAW.
REQ-016 done  output  1  high in DONE.

Function
REQ-017 States SHALL be IDLE, DRAW, DONE.
REQ-018 IDLE with start=1 SHALL, on that edge, capture xmin=min(x0,x1), xmax=max(x0,x1), ymin, ymax, mode, color_in; set x=xmin, y=ymin; go to DRAW.
REQ-019 Traversal order SHALL be raster: x increments xmin..xmax, then x returns to xmin and y increments, ending at (xmax,ymax), independent of corner order.
REQ-020 In mode 1, on rows with ymin<y<ymax, x SHALL jump directly from xmin to xmax; rows ymin and ymax and all degenerate rectangles (xmin==xmax or ymin==ymax) SHALL be traversed fully.
REQ-021 valid SHALL equal (state==DRAW) and 0<=x<SCREEN_W and 0<=y<SCREEN_H, evaluated combinationally from registered x, y.
REQ-022 In DRAW, the position SHALL advance on an edge where valid&ready=1 or valid=0 (off-screen pixels consume one cycle, no handshake).
REQ-023 In DRAW with valid=1 and ready=0, x, y, color SHALL hold.
REQ-024 Each on-screen pixel SHALL be offered exactly once and accepted exactly once; no duplicates, no gaps.
REQ-025 When the position (xmax,ymax) advances, the next state SHALL be DONE; x, y hold their last values.
REQ-026 A 1x1 rectangle SHALL produce exactly one pixel then DONE.
REQ-027 DONE SHALL remain while start=1 and SHALL return to IDLE on the first edge with start=0.
REQ-028 start, corners, mode, color_in SHALL be ignored in DRAW and DONE.
REQ-029 Arithmetic SHALL be signed COORD_W; min/max comparisons signed; no wrap for inputs in range -2^(COORD_W-1)..2^(COORD_W-1)-2.
REQ-030 Throughput SHALL be one pixel per cycle with ready held high.
REQ-031 First pixel SHALL appear on x, y the cycle after start is sampled.

Reset
REQ-032 reset=1 SHALL force IDLE and x=0, y=0, color=0, valid=0, busy=0, done=0 on the next edge, overriding start and any mid-operation traversal.
REQ-033 After reset deasserts, a held start=1 SHALL begin a new draw on the next edge.

Verification
REQ-034 Corners (3,2),(1,1), mode 0, ready=1 -> six pixels (1,1),(2,1),(3,1),(1,2),(2,2),(3,2) on consecutive cycles, then done.
REQ-035 Corners (0,0),(3,3), mode 1 -> twelve pixels; row y=1 emits only x=0 and x=3.
REQ-036 Corners (-2,0),(1,0), mode 0 -> valid low for x=-2,-1, pixels (0,0),(1,0) valid; done after 4 DRAW cycles.
REQ-037 Corners (5,5),(5,5) with ready low 3 cycles -> (5,5) held with valid=1 for 4 cycles, accepted once, then done.
REQ-038 reset mid-draw of (0,0),(9,9) -> IDLE and all outputs zero next edge; new start redraws from (0,0).
REQ-039 start held high through DONE -> done stays high; start low -> IDLE next edge, no new draw.
